// File: rtl/fp16_pkg.sv
// Shared FP16 constants, accumulator flag bit positions and the accumulator
// FSM state encoding.
package fp16_pkg;

    localparam int              FP16_BIAS    = 15;
    localparam logic [4:0]      FP16_EXP_MAX = 5'h1F;
    localparam logic [15:0]     FP16_QNAN    = 16'h7E00;
    localparam logic [15:0]     FP16_POS_INF = 16'h7C00;
    localparam logic [14:0]     FP16_MAX_FIN = 15'h7BFF;

    localparam int              FLG_OVF      = 3;
    localparam int              FLG_ZERO     = 2;
    localparam int              FLG_CARRY    = 1;
    localparam int              FLG_NEG      = 0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

endpackage

// File: rtl/fp16_mul_accum_if.sv
// Product-in / accumulator-out bundle of the FP16 accumulator.
// master = producer/observer side, slave = the accumulator itself.
interface fp16_mul_accum_if #(
    parameter int CNT_W = 8
);
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_prod;
    logic [15:0]      acc;
    logic [CNT_W-1:0] acc_count;
    logic             done;
    logic [3:0]       flags;

    modport master (
        output clear, in_valid, in_prod,
        input  in_ready, acc, acc_count, done, flags
    );

    modport slave (
        input  clear, in_valid, in_prod,
        output in_ready, acc, acc_count, done, flags
    );
endinterface

// File: rtl/fp16_lzc12.sv
// Combinational leading-zero counter for the 12-bit sum of the accumulator.
// An all-zero input reports 12.
module fp16_lzc12 (
    input  logic [11:0] value,
    output logic [3:0]  count
);

    // Scan upward so the highest set bit is the one that decides the count.
    always_comb begin
        count = 4'd12;
        for (int i = 0; i < 12; i++) begin
            if (value[i]) count = 4'(11 - i);
        end
    end

endmodule

// File: rtl/fp16_mul_accum.sv
// FP16 accumulator (MAC back end): adds each accepted half-precision product
// into a running sum through a fixed ALIGN/ADD/NORM/WRITE sequence.
// Truncating arithmetic, subnormal inputs flushed to zero.
// Optional build macro FP16_ACC_SAT_EN: finite overflow saturates to the
// largest finite magnitude instead of producing infinity.
module fp16_mul_accum
    import fp16_pkg::*;
#(
    parameter int BIAS  = FP16_BIAS,
    parameter int CNT_W = 8
) (
    input logic             clk,
    input logic             reset,
    fp16_mul_accum_if.slave bus
);

    // All-ones biased exponent (31 for half precision).
    localparam logic signed [6:0] EXP_TOP    = 7'(2 * BIAS + 1);
    localparam logic [3:0]        ZERO_FLAGS = 4'b0100;

    function automatic logic [15:0] ovf_result(input logic sign);
`ifdef FP16_ACC_SAT_EN
        return {sign, FP16_MAX_FIN};
`else
        return {sign, FP16_POS_INF[14:0]};
`endif
    endfunction

    state_t            state;
    logic [15:0]       acc_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              done_r;
    logic [3:0]        flags_r;
    logic              ready_r;

    logic [15:0]       a_p0, b_p0;

    logic [4:0]        ea, eb, exp_l, exp_s, diff;
    logic              za, zb, a_big, sign_l, sign_s;
    logic [10:0]       ma, mb, m_l, m_small, m_s;
    logic [14:0]       mag_a, mag_b;
    logic              nan_a, nan_b, inf_a, inf_b, spec;
    logic [15:0]       spec_val;

    logic              sign_l_p1, sign_s_p1, spec_p1;
    logic [4:0]        exp_p1;
    logic [10:0]       ml_p1, ms_p1;
    logic [15:0]       spec_val_p1;

    logic [11:0]       sum;

    logic              sign_p2, spec_p2;
    logic [4:0]        exp_p2;
    logic [11:0]       sum_p2;
    logic [15:0]       spec_val_p2;

    logic [3:0]        lz, shamt;
    logic signed [6:0] exp_n;
    logic [9:0]        frac;
    logic [15:0]       res;
    logic [3:0]        res_flags;
    logic              nan_out;

    fp16_lzc12 u_lzc (
        .value (sum_p2),
        .count (lz)
    );

    // ALIGN: unpack, order by magnitude, shift the smaller significand, detect specials.
    always_comb begin
        ea    = a_p0[14:10];
        eb    = b_p0[14:10];
        za    = (ea == 5'd0);
        zb    = (eb == 5'd0);
        ma    = za ? 11'd0 : {1'b1, a_p0[9:0]};
        mb    = zb ? 11'd0 : {1'b1, b_p0[9:0]};
        mag_a = za ? 15'd0 : a_p0[14:0];
        mag_b = zb ? 15'd0 : b_p0[14:0];
        a_big = (mag_a >= mag_b);

        sign_l  = a_big ? a_p0[15] : b_p0[15];
        sign_s  = a_big ? b_p0[15] : a_p0[15];
        exp_l   = a_big ? ea : eb;
        exp_s   = a_big ? eb : ea;
        m_l     = a_big ? ma : mb;
        m_small = a_big ? mb : ma;
        diff    = exp_l - exp_s;
        m_s     = (diff >= 5'd12) ? 11'd0 : (m_small >> diff);

        nan_a = (ea == FP16_EXP_MAX) && (a_p0[9:0] != 10'd0);
        nan_b = (eb == FP16_EXP_MAX) && (b_p0[9:0] != 10'd0);
        inf_a = (ea == FP16_EXP_MAX) && (a_p0[9:0] == 10'd0);
        inf_b = (eb == FP16_EXP_MAX) && (b_p0[9:0] == 10'd0);
        spec  = (ea == FP16_EXP_MAX) || (eb == FP16_EXP_MAX);
        if (nan_a || nan_b || (inf_a && inf_b && (a_p0[15] != b_p0[15])))
            spec_val = FP16_QNAN;
        else if (inf_a)
            spec_val = {a_p0[15], FP16_POS_INF[14:0]};
        else
            spec_val = {b_p0[15], FP16_POS_INF[14:0]};
    end

    // ADD: same signs add (bit 11 is the carry-out), else larger minus smaller.
    always_comb begin
        if (sign_l_p1 == sign_s_p1)
            sum = {1'b0, ml_p1} + {1'b0, ms_p1};
        else
            sum = {1'b0, ml_p1} - {1'b0, ms_p1};
    end

    // NORM: renormalise the sum, apply underflow/overflow and special results.
    always_comb begin
        shamt     = lz - 4'd1;
        exp_n     = 7'sd0;
        frac      = 10'd0;
        res       = 16'h0000;
        res_flags = 4'b0000;
        nan_out   = spec_p2 && (spec_val_p2 == FP16_QNAN);
        if (spec_p2) begin
            res = spec_val_p2;
        end else if (sum_p2 != 12'd0) begin
            if (sum_p2[11]) begin
                exp_n = $signed({2'b00, exp_p2}) + 7'sd1;
                frac  = sum_p2[10:1];
            end else begin
                exp_n = $signed({2'b00, exp_p2}) - $signed({3'b000, shamt});
                frac  = 10'(sum_p2 << shamt);
            end
            if (exp_n <= 7'sd0)
                res = {sign_p2, 15'd0};
            else if (exp_n >= EXP_TOP)
                res = ovf_result(sign_p2);
            else
                res = {sign_p2, exp_n[4:0], frac};
            res_flags[FLG_OVF]   = (exp_n >= EXP_TOP);
            res_flags[FLG_CARRY] = sum_p2[11];
        end
        res_flags[FLG_ZERO] = (res[14:0] == 15'd0) || nan_out;
        res_flags[FLG_NEG]  = res[15];
    end

    // Datapath registers: operands captured on accept, later stages free-running.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.in_valid) begin
            a_p0 <= bus.clear ? 16'h0000 : acc_r;
            b_p0 <= bus.in_prod;
        end
        // ---- ALIGN -> ADD boundary ----
        sign_l_p1   <= sign_l;
        sign_s_p1   <= sign_s;
        exp_p1      <= exp_l;
        ml_p1       <= m_l;
        ms_p1       <= m_s;
        spec_p1     <= spec;
        spec_val_p1 <= spec_val;
        // ---- ADD -> NORM boundary ----
        sign_p2     <= sign_l_p1;
        exp_p2      <= exp_p1;
        sum_p2      <= sum;
        spec_p2     <= spec_p1;
        spec_val_p2 <= spec_val_p1;
    end

    // Control FSM with registered handshake, accumulator, counter and flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            acc_r   <= 16'h0000;
            cnt_r   <= '0;
            done_r  <= 1'b0;
            flags_r <= ZERO_FLAGS;
            ready_r <= 1'b1;
        end else begin
            done_r <= 1'b0;
            if (bus.clear) begin
                acc_r   <= 16'h0000;
                cnt_r   <= '0;
                flags_r <= ZERO_FLAGS;
            end
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        state   <= S_ALIGN;
                        ready_r <= 1'b0;
                    end
                end
                S_ALIGN: begin
                    state   <= bus.clear ? S_IDLE : S_ADD;
                    ready_r <= bus.clear;
                end
                S_ADD: begin
                    state   <= bus.clear ? S_IDLE : S_NORM;
                    ready_r <= bus.clear;
                end
                S_NORM: begin
                    if (bus.clear) begin
                        state   <= S_IDLE;
                        ready_r <= 1'b1;
                    end else begin
                        state   <= S_WRITE;
                        acc_r   <= res;
                        flags_r <= res_flags;
                        cnt_r   <= cnt_r + 1'b1;
                        done_r  <= 1'b1;
                    end
                end
                S_WRITE: begin
                    state   <= S_IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = ready_r;
    assign bus.acc       = acc_r;
    assign bus.acc_count = cnt_r;
    assign bus.done      = done_r;
    assign bus.flags     = flags_r;

endmodule

// File: doc/fp16_mul_accum.md
Name: fp16_mul_accum

Overview:
- Downstream consumer of the FP16 multiplier. Accumulates a stream of IEEE-754 half-precision products into a running sum (the MAC back end).
- Multi-cycle: fixed four-stage FSM per accepted product, with a valid/ready input handshake.
- Number rules match the multiplier: truncation, subnormals flushed to zero, flag order [overflow, zero, carry, negative].

Parameters:
- BIAS, 15, half-precision exponent bias.
- CNT_W, 8, width of accepted-product counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous: zero accumulator and counter.
- in_valid  in  1  product operand valid.
- in_ready  out  1  block can accept an operand (high only in IDLE).
- in_prod  in  16  FP16 product (multiplier mul16 output).
- acc  out  16  current FP16 accumulator value.
- acc_count  out  CNT_W  number of products accumulated since clear; wraps.
- done  out  1  one-cycle pulse: acc/flags updated.
- flags  out  4  [3] overflow, [2] zero, [1] carry (mantissa add carry-out), [0] negative; registered with acc.

Behaviour:
- Reset (asynchronous, active-high): acc=16'h0000, acc_count=0, done=0, flags=4'b0100 (zero set), FSM=IDLE, in_ready=1.
- FSM: IDLE -> ALIGN -> ADD -> NORM -> WRITE -> IDLE.
- Accept happens on in_valid & in_ready in IDLE.
- Latency: done pulses in the WRITE cycle, exactly 4 cycles after accept. acc, flags and acc_count update on that same edge. Peak throughput is 1 product per 5 cycles.
- Unpack: exponent==0 is treated as zero (flush); otherwise hidden bit 1, 11-bit mantissa.
- ALIGN: larger-magnitude operand selected. Smaller mantissa is shifted right by the exponent difference (shift >= 12 gives 0). Shifted-out bits are discarded (truncation, no guard bits).
- ADD: 12-bit mantissa path. Equal signs: add; carry-out sets flags[1]. Differing signs: larger minus smaller; result sign = sign of larger.
- NORM:
  - Carry: shift right 1, exp+1.
  - Otherwise: leading-zero shift left, exp minus shift count.
  - Exact cancellation: result +0 (16'h0000).
  - exp <= 0 after normalise: signed zero {sign, 15'b0}, zero flag set.
  - exp >= 31 after normalise: {sign, 5'h1F, 10'h0}, overflow flag set.
- Specials (either operand exponent==31):
  - Any NaN, or Inf + opposite-sign Inf: 16'h7E00, zero flag set.
  - Otherwise: Inf with the Inf operand's sign.
  - NaN/Inf in acc is sticky until clear or reset.
- flags[0] = acc[15] after update. flags[2] = (acc[14:0]==0) or NaN case.
- clear in IDLE without in_valid: acc=0, acc_count=0, flags=4'b0100; no done pulse.
- clear together with an accept in IDLE: the sum starts from +0, so the result equals in_prod; acc_count ends at 1.
- clear while busy: operation aborted, return to IDLE next cycle with acc=0 and count=0, no done pulse.
- in_valid outside IDLE is ignored (in_ready=0); in_prod need only be stable in the accept cycle.
- acc_count wraps from all-ones to 0, with no flag.

Optional Feature:
- Macro FP16_ACC_SAT_EN.
- Defined: a finite-operand overflow saturates to max finite (16'h7BFF / 16'hFBFF) with flags[3] still set. Inf/NaN inputs are unaffected.
- Undefined: overflow produces ±Inf as above.

Decomposition:
- Shared package fp16_pkg holds:
  - constants: FP16_BIAS=15, FP16_EXP_MAX=5'h1F, FP16_QNAN=16'h7E00, FP16_POS_INF=16'h7C00, FP16_MAX_FIN=15'h7BFF;
  - flag bit indices: FLG_OVF=3, FLG_ZERO=2, FLG_CARRY=1, FLG_NEG=0;
  - FSM state encoding.
- One sub-module, fp16_lzc12: combinational 12-bit leading-zero counter used in NORM.
- Alignment and add stay in the top.

Test Plan:
- Reset, clear, then accept 0x3C00 followed by 0x4000 -> done 4 cycles after each accept; acc 0x3C00 then 0x4200; acc_count=2; flags=0000.
- acc=0x4200, accept 0xC200 -> acc=0x0000, flags=0100.
- acc=0x3C00: accept 0x1400 -> 0x3C01. Separately, from acc=0x3C00, accept 0x1000 -> 0x3C00 (truncated).
- acc=0x7BFF, accept 0x7BFF:
  - without macro -> 0x7C00, flags=1010 (overflow + carry);
  - with FP16_ACC_SAT_EN -> 0x7BFF, flags=1010.
- Accept 0x7E00 then 0x3C00 -> acc stays 0x7E00 (sticky); clear -> 0x0000, count=0.
- clear asserted 2 cycles after an accept -> no done pulse, acc=0x0000, in_ready high next cycle. Also check asynchronous reset mid-ADD returns all outputs to reset values.
